// File: rtl/logic_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_arbiter_if
// Description : Request/response bundle between the logic-op issuers and the
//               shared logic-op arbiter. Requests are packed per requester;
//               the response channel is a single tagged stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_op_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  // Per-requester request channel
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;

  // Shared response channel
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  // Status
  logic                   busy;

  // Issuer/consumer side
  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_arbiter
// Description : Shares one bitwise logic unit (OR/AND/XOR/NOR) among N_REQ
//               requesters. Round-robin grant in IDLE, one registered execute
//               cycle, then a tagged response held until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_op_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] c_OP_OR  = 2'b00;
  localparam logic [1:0] c_OP_AND = 2'b01;
  localparam logic [1:0] c_OP_XOR = 2'b10;
  localparam logic [1:0] c_OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_gid;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W:0]    w_scan;
  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic [ID_W-1:0]  w_ptr_next;

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_scan >= (ID_W+1)'(N_REQ)) begin
        w_scan = w_scan - (ID_W+1)'(N_REQ);
      end
      if (!w_found && bus.req_valid[w_scan[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_scan[ID_W-1:0];
      end
    end
  end

  // A grant is only offered in IDLE; reset forces it low asynchronously.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      bus.req_ready[w_grant] = 1'b1;
    end
  end

  // The offered requester is valid by construction, so an offer is a handshake.
  assign w_accept   = (r_state == S_IDLE) && w_found;
  assign w_ptr_next = (w_grant == ID_W'(N_REQ - 1)) ? '0 : (w_grant + 1'b1);

  // Shared logic unit operating on the latched request.
  always_comb begin
    w_result = '0;
    case (r_op)
      c_OP_OR:  w_result = r_x | r_y;
      c_OP_AND: w_result = r_x & r_y;
      c_OP_XOR: w_result = r_x ^ r_y;
      c_OP_NOR: w_result = ~(r_x | r_y);
      default:  w_result = '0;
    endcase
  end

  // Next-state logic: one execute cycle, response held until consumed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the winning request and advance priority past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gid    <= '0;
      r_op     <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_ptr_next;
      r_gid    <= w_grant;
      r_op     <= bus.req_op[2*w_grant +: 2];
      r_x      <= bus.req_x[WIDTH*w_grant +: WIDTH];
      r_y      <= bus.req_y[WIDTH*w_grant +: WIDTH];
    end
  end

  // Response register: loaded in EXEC, valid held through RESP until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (r_state == S_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_gid;
        r_rsp_data  <= w_result;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_op_arbiter
// Description : Self-checking bench for logic_op_arbiter: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_op_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_op_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (op)
      2'd0:    return x | y;
      2'd1:    return x & y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  int         m_ptr      = 0;  // requester with top priority
  bit         m_inflight = 0;  // an accepted op has not yet been consumed
  int         m_age      = 0;  // edges since the op was accepted (saturates at 1)
  int         m_id       = 0;
  logic [W-1:0] m_data   = '0;
  logic [N-1:0] m_hs     = '0; // requesters handshaked on the last edge
  int         tb_win;

  always_comb tb_win = winner(bus.req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_inflight <= 1'b0; m_age <= 0; m_id <= 0; m_data <= '0; m_hs <= '0;
    end else begin
      m_hs <= '0;
      if (!m_inflight) begin
        if (tb_win >= 0) begin
          m_inflight     <= 1'b1;
          m_age          <= 0;
          m_id           <= tb_win;
          m_data         <= apply_op(bus.req_op[2*tb_win +: 2], bus.req_x[W*tb_win +: W],
                                     bus.req_y[W*tb_win +: W]);
          m_ptr          <= (tb_win + 1) % N;
          m_hs[tb_win]   <= 1'b1;
        end
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if (bus.rsp_ready) begin
        m_inflight <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [N-1:0] c_exp_ready;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
    end else begin
      c_exp_ready = '0;
      if (!m_inflight && tb_win >= 0) c_exp_ready[tb_win] = 1'b1;
      chk("cyc_req_ready", bus.req_ready, c_exp_ready);
      chk("cyc_rsp_valid", bus.rsp_valid, (m_inflight && m_age >= 1));
      chk("cyc_busy", bus.busy, m_inflight);
      if (m_inflight && m_age >= 1) begin
        chk("cyc_rsp_data", bus.rsp_data, m_data);
        chk("cyc_rsp_id", bus.rsp_id, m_id);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    bus.req_op[2*i +: 2] = op;
    bus.req_x[W*i +: W]  = x;
    bus.req_y[W*i +: W]  = y;
  endtask

  // Issue one op on requester i alone and return the response (rsp_ready=1).
  task automatic run_op(input int i, input logic [1:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] d, output int id);
    int n;
    set_req(i, op, x, y);
    bus.req_valid[i] = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready[i] && n < 10) begin tick(); #1; n++; end
    chk("grant_timeout", (n < 10), 1);
    tick();
    bus.req_valid[i] = 1'b0;
    n = 0;
    #1;
    while (!bus.rsp_valid && n < 10) begin tick(); #1; n++; end
    chk("rsp_timeout", (n < 10), 1);
    d  = bus.rsp_data;
    id = int'(bus.rsp_id);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] d;
    int           id;
    int           gr[$];
    int           gc[$];
    int           ids[$];
    int           n;

    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset: grant must stay low even with requests pending.
    bus.req_valid = 4'b1111;
    #2;
    chk("reset_req_ready", bus.req_ready, 4'b0000);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single op with exact latency.
    set_req(0, 2'b00, 8'hA5, 8'h0F);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    #1;
    chk("single_exec_valid", bus.rsp_valid, 0);
    chk("single_exec_busy", bus.busy, 1);
    tick(); #1;
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_data", bus.rsp_data, 8'hAF);
    chk("single_rsp_id", bus.rsp_id, 0);
    tick(); #1;
    chk("single_done_valid", bus.rsp_valid, 0);
    chk("single_done_busy", bus.busy, 0);
    tick();

    // Op coverage on requester 2.
    run_op(2, 2'b00, 8'hCC, 8'hAA, d, id); chk("op_or", d, 8'hEE);  chk("op_or_id", id, 2);
    run_op(2, 2'b01, 8'hCC, 8'hAA, d, id); chk("op_and", d, 8'h88); chk("op_and_id", id, 2);
    run_op(2, 2'b10, 8'hCC, 8'hAA, d, id); chk("op_xor", d, 8'h66); chk("op_xor_id", id, 2);
    run_op(2, 2'b11, 8'hCC, 8'hAA, d, id); chk("op_nor", d, 8'h11); chk("op_nor_id", id, 2);

    // Round-robin from a fresh pointer.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 8'(i * 17 + 3), 8'(8'h5A ^ i));
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin gr.push_back(i); gc.push_back(c); end
      end
      if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
      tick();
    end
    bus.req_valid = '0;
    chk("rr_grant_count", gr.size(), 5);
    chk("rr_rsp_count", ids.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gr.size()) chk("rr_grant_order", gr[k], k % 4);
      if (k > 0 && k < gc.size()) chk("rr_grant_spacing", gc[k] - gc[k-1], 3);
      if (k < ids.size()) chk("rr_rsp_id_order", ids[k], k % 4);
    end

    // Back-pressure: response held while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    set_req(1, 2'b10, 8'h3C, 8'h0F);
    bus.req_valid = 4'b0010;
    n = 0;
    #1;
    while (!bus.req_ready[1] && n < 10) begin tick(); #1; n++; end
    chk("bp_grant_timeout", (n < 10), 1);
    tick();
    bus.req_valid = 4'b1111;
    n = 0;
    #1;
    while (!bus.rsp_valid && n < 10) begin tick(); #1; n++; end
    chk("bp_rsp_timeout", (n < 10), 1);
    chk("bp_data", bus.rsp_data, 8'h33);
    chk("bp_id", bus.rsp_id, 1);
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_data", bus.rsp_data, 8'h33);
      chk("bp_hold_id", bus.rsp_id, 1);
      chk("bp_hold_ready", bus.req_ready, 0);
      chk("bp_hold_busy", bus.busy, 1);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick(); #1;
    chk("bp_release_valid", bus.rsp_valid, 0);
    chk("bp_release_busy", bus.busy, 0);
    tick();

    // Priority rotation: after granting 1, search starts at 2 and wraps to 0.
    run_op(1, 2'b00, 8'h01, 8'h02, d, id);
    chk("rot_first_id", id, 1);
    bus.req_valid = 4'b0011;
    #1;
    chk("rot_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    repeat (2) tick();

    // Mid-op reset during EXEC.
    set_req(2, 2'b01, 8'hF0, 8'h3C);
    bus.req_valid = 4'b0100;
    #1;
    chk("mid_ready", bus.req_ready, 4'b0100);
    tick();
    #1;
    chk("mid_exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_ptr_zero", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0100;
    #1;
    chk("mid_regrant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    repeat (2) tick();
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_ptr_after", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    tick();

    // Randomized traffic: withdrawal allowed, operands frozen while waiting.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && !m_hs[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
